// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        FLUSH = 2'b11
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & 64'hFFFF_FFFF_FFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, inst} entries with a registered
// head so the decoder-facing outputs come straight from flops.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output logic                       head_valid,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W:0]         count_r;
    logic                   head_valid_r;
    fetch_entry_t           head_r;

    logic                   pop_s;
    logic                   push_s;
    logic [PTR_W-1:0]       rd_ptr_nxt_s;
    logic [PTR_W:0]         remain_s;
    logic [PTR_W:0]         count_nxt_s;
    fetch_entry_t           head_nxt_s;

    assign head_valid = head_valid_r;
    assign head_entry = head_r;
    assign count      = count_r;

    // Next pointer/occupancy and the entry that becomes the new head
    always_comb begin
        pop_s        = pop && head_valid_r;
        remain_s     = count_r - (PTR_W+1)'(pop_s);
        push_s       = push && (remain_s < (PTR_W+1)'(DEPTH));
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
        count_nxt_s  = remain_s + (PTR_W+1)'(push_s);
        if (remain_s == {(PTR_W+1){1'b0}}) begin
            // Nothing older left: the head (if any) is the word arriving now.
            head_nxt_s = push_entry;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage, written at the tail on every accepted push
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers, occupancy and registered head; flush wins over push and pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {(PTR_W+1){1'b0}};
            head_valid_r <= 1'b0;
            head_r       <= '{pc: {ADDR_W{1'b0}}, inst: {INST_W{1'b0}}};
        end else if (flush) begin
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {(PTR_W+1){1'b0}};
            head_valid_r <= 1'b0;
        end else begin
            rd_ptr_r     <= rd_ptr_nxt_s;
            wr_ptr_r     <= wr_ptr_r + PTR_W'(push_s);
            count_r      <= count_nxt_s;
            head_valid_r <= (count_nxt_s != {(PTR_W+1){1'b0}});
            head_r       <= head_nxt_s;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding 32-bit read
// at a time and queues returned words with their PCs for the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_inhibit,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  req_pc_r;
    logic               mem_req_valid_r;
    logic [ADDR_W-1:0]  mem_req_addr_r;

    logic [CNT_W-1:0]   count_s;
    logic               in_flight_s;
    logic               launch_s;
    logic               push_s;
    fetch_entry_t       push_entry_s;
    logic               head_valid_s;
    fetch_entry_t       head_entry_s;

    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign inst_valid    = head_valid_s;
    assign inst_data     = head_entry_s.inst;
    assign inst_pc       = head_entry_s.pc;

    // Launch credit check and queue push decision
    always_comb begin
        in_flight_s = (state_r != IDLE);
        if ((state_r == IDLE) && !pc_inhibit && !redirect_valid &&
            ((count_s + CNT_W'(in_flight_s)) < CNT_W'(FIFO_DEPTH))) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
        // A response coinciding with a redirect belongs to the old stream.
        push_s            = (state_r == WAIT) && mem_rsp_valid && !redirect_valid;
        push_entry_s.pc   = req_pc_r;
        push_entry_s.inst = mem_rsp_data;
    end

    // Request sequencing FSM and program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            pc_r            <= RESET_PC;
            req_pc_r        <= {ADDR_W{1'b0}};
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            // A redirect target takes priority over the sequential advance.
            if (redirect_valid) begin
                pc_r <= align_pc(redirect_pc);
            end else if ((state_r == REQ) && mem_req_ready) begin
                pc_r <= pc_r + PC_STEP;
            end

            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        state_r         <= REQ;
                        mem_req_valid_r <= 1'b1;
                        mem_req_addr_r  <= pc_r;
                        req_pc_r        <= pc_r;
                    end
                end
                REQ: begin
                    // The request is never withdrawn; only acceptance drops it.
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                    end
                    if (redirect_valid) begin
                        state_r <= FLUSH;
                    end else if (mem_req_ready) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state_r <= IDLE;
                    end else if (redirect_valid) begin
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    // A stale request may still be waiting for acceptance here.
                    if (mem_req_valid_r) begin
                        if (mem_req_ready) begin
                            mem_req_valid_r <= 1'b0;
                        end
                    end else if (mem_rsp_valid) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    mem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (inst_ready),
        .head_valid (head_valid_s),
        .head_entry (head_entry_s),
        .count      (count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model tracks the
// next fetch address, the single outstanding request and the stream of
// instructions the decoder must see, while a behavioural memory answers reads.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_inhibit;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_inhibit(pc_inhibit),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_entry_t;

    int tests = 0;
    int fails = 0;

    // reference model state
    exp_entry_t  exp_q[$];
    logic [63:0] req_log[$];
    logic [63:0] model_pc;
    logic [63:0] pend_addr;
    bit          busy, accepted, discard, launch_pred;
    int          rsp_wait, acc_count;

    // stimulus knobs: 0 = low, 1 = high, 2 = random
    int          inhibit_mode, ready_mode, iready_mode;
    int          lat_lo, lat_hi, redir_pct;
    bit          redir_force;
    logic [63:0] redir_target;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [63:0] log_at(input int i);
        if (i >= 0 && i < req_log.size()) return req_log[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int mode, input int pct);
        if (mode == 2) return ($urandom_range(99, 0) < pct);
        return (mode == 1);
    endfunction

    // One clock: check outputs at the negedge, drive inputs, update model after posedge.
    task automatic cycle();
        logic acc, rsp, pop, redir;
        logic [63:0] tgt;
        if (!busy) begin
            check("req_launch", 64'(mem_req_valid), 64'(launch_pred));
            if (mem_req_valid) begin
                check("req_addr", mem_req_addr, model_pc);
                busy = 1'b1; accepted = 1'b0; discard = 1'b0;
                pend_addr = mem_req_addr;
                req_log.push_back(mem_req_addr);
            end
        end else if (!accepted) begin
            check("req_hold_valid", 64'(mem_req_valid), 64'd1);
            check("req_hold_addr", mem_req_addr, pend_addr);
        end else begin
            check("req_quiet", 64'(mem_req_valid), 64'd0);
        end
        check("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
        if (inst_valid && exp_q.size() != 0) begin
            check("inst_pc", inst_pc, exp_q[0].pc);
            check("inst_data", 64'(inst_data), 64'(exp_q[0].inst));
        end

        pc_inhibit    = pick(inhibit_mode, 20);
        mem_req_ready = pick(ready_mode, 50);
        inst_ready    = pick(iready_mode, 60);
        if (redir_force) begin
            redirect_valid = 1'b1; redirect_pc = redir_target; redir_force = 1'b0;
        end else if (redir_pct > 0 && $urandom_range(99, 0) < redir_pct) begin
            redirect_valid = 1'b1; redirect_pc = {$urandom, $urandom};
        end else begin
            redirect_valid = 1'b0;
        end
        if (busy && accepted && rsp_wait == 0) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = mem_word(pend_addr);
        end else begin
            mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
            if (busy && accepted) rsp_wait--;
        end
        launch_pred = !busy && !pc_inhibit && !redirect_valid && (exp_q.size() < DEPTH);
        acc = mem_req_valid && mem_req_ready;
        rsp = mem_rsp_valid;
        pop = inst_valid && inst_ready;
        redir = redirect_valid;
        tgt = redirect_pc;

        @(posedge clk);
        if (pop && !redir) void'(exp_q.pop_front());
        if (rsp) begin
            if (!discard && !redir) exp_q.push_back('{pc: pend_addr, inst: mem_word(pend_addr)});
            busy = 1'b0; accepted = 1'b0;
        end
        if (acc) begin
            accepted = 1'b1; acc_count++;
            rsp_wait = $urandom_range(lat_hi, lat_lo);
            if (!discard && !redir) model_pc = pend_addr + 64'd4;
        end
        if (redir) begin
            exp_q.delete();
            model_pc = {tgt[63:2], 2'b00};
            if (busy) discard = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        inhibit_mode = 1; iready_mode = 1; ready_mode = 1;
        redir_pct = 0; lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 100 && (busy || exp_q.size() != 0); i++) cycle();
        check("drain_done", 64'(busy || exp_q.size() != 0), 64'd0);
    endtask

    initial begin
        int idx, acc0;
        logic [63:0] wpc;
        reset = 1'b1; pc_inhibit = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; inst_ready = 1'b0;
        model_pc = RPC; pend_addr = 64'd0; busy = 1'b0; accepted = 1'b0; discard = 1'b0;
        launch_pred = 1'b0; rsp_wait = 0; acc_count = 0; redir_force = 1'b0; redir_target = 64'd0;
        inhibit_mode = 0; ready_mode = 1; iready_mode = 1; lat_lo = 0; lat_hi = 0; redir_pct = 0;
        repeat (3) @(negedge clk);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_req_addr", mem_req_addr, 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_data", 64'(inst_data), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        reset = 1'b0;

        // sequential fetch from the reset PC with an always-ready 1-cycle memory
        repeat (20) cycle();
        check("seq_addr0", log_at(0), 64'h1000);
        check("seq_addr1", log_at(1), 64'h1004);
        check("seq_addr2", log_at(2), 64'h1008);

        // decoder stalled: exactly DEPTH requests, then one more per pop
        drain();
        inhibit_mode = 0; iready_mode = 0; acc0 = acc_count;
        repeat (30) cycle();
        check("stall_reqs", 64'(acc_count - acc0), 64'd4);
        iready_mode = 1; cycle(); iready_mode = 0; acc0 = acc_count;
        repeat (20) cycle();
        check("one_pop_one_req", 64'(acc_count - acc0), 64'd1);

        // redirect to an unaligned target while a response is awaited
        drain();
        inhibit_mode = 0; lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20 && !(busy && accepted); i++) cycle();
        check("wait_reached", 64'(busy && accepted), 64'd1);
        redir_target = 64'h2003; redir_force = 1'b1; idx = req_log.size();
        for (int i = 0; i < 30 && req_log.size() <= idx; i++) cycle();
        check("redir_wait_addr", log_at(idx), 64'h2000);

        // redirect while the request is held off by the memory
        drain();
        inhibit_mode = 0; ready_mode = 0; lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 10 && !busy; i++) cycle();
        check("req_pending", 64'(busy && !accepted), 64'd1);
        redir_target = 64'h3000; redir_force = 1'b1;
        repeat (3) cycle();
        ready_mode = 1; idx = req_log.size();
        for (int i = 0; i < 30 && req_log.size() <= idx; i++) cycle();
        check("redir_req_addr", log_at(idx), 64'h3000);

        // PC wrap at the top of the address space
        drain();
        redir_target = 64'hFFFF_FFFF_FFFF_FFFC; redir_force = 1'b1; cycle();
        inhibit_mode = 0; idx = req_log.size();
        for (int i = 0; i < 30 && req_log.size() < idx + 2; i++) cycle();
        check("wrap_top", log_at(idx), 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_zero", log_at(idx + 1), 64'h0);

        // inhibit raised mid-WAIT: in-flight word still lands, nothing new issues
        drain();
        inhibit_mode = 0; iready_mode = 0; lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20 && !(busy && accepted); i++) cycle();
        inhibit_mode = 1; acc0 = acc_count; wpc = pend_addr;
        repeat (15) cycle();
        check("inhibit_no_req", 64'(acc_count - acc0), 64'd0);
        check("inhibit_queued_valid", 64'(inst_valid), 64'd1);
        check("inhibit_queued_pc", inst_pc, wpc);

        // randomized traffic: memory stalls, latency, decoder back-pressure, redirects
        drain();
        inhibit_mode = 2; ready_mode = 2; iready_mode = 2;
        lat_lo = 0; lat_hi = 3; redir_pct = 3;
        repeat (3000) cycle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
